// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-ported word memory that answers one load/store request at a time,
// with a programmable number of wait states between acceptance and completion.
//
// Request handshake: a request is taken on any rising Clk edge where
// req=1 and ready=1. The request fields are captured on that edge, so the
// initiator may change them on the following cycle. Completion is signalled
// by a one-cycle done pulse, WAIT_CYCLES+1 cycles after the accepting edge.
//
// Parameters
//   ADDR_BITS   - implemented word-address bits (2^ADDR_BITS x 16-bit words)
//   WAIT_CYCLES - wait states between accept and completion (0..15)
//
// Ports
//   Clk      in   clock, rising-edge
//   Rst      in   synchronous active-high reset
//   req      in   request valid
//   we       in   1 = store, 0 = load
//   addr     in   [15:0] word address
//   wdata    in   [15:0] store data
//   ready    out  request can be accepted this cycle
//   done     out  one-cycle completion pulse
//   rdata    out  [15:0] load data, valid with done on a load; held after
//   addr_err out  one-cycle pulse with done for an out-of-range address
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic        addr_err
);

    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        accept;

    // Request captured at accept; the live inputs are ignored afterwards.
    logic [15:0] addr_q;
    logic        we_q;
    logic [15:0] wdata_q;

    // Last completed load value, presented whenever no load is completing.
    logic [15:0] rdata_q;

    logic [15:0] mem [0:DEPTH-1];

    logic                 in_range;
    logic [ADDR_BITS-1:0] index;
    logic [15:0]          load_data;
    logic                 resp_load;
    logic                 resp_store;

    // Upper address bits beyond the implemented range must all be zero.
    assign in_range  = ((addr_q >> ADDR_BITS) == 16'h0000);
    assign index     = addr_q[ADDR_BITS-1:0];
    assign load_data = in_range ? mem[index] : 16'h0000;

    // An asserted Rst aborts whatever is in flight, including a RESP cycle,
    // so the completion outputs are suppressed while it is high.
    assign resp_load  = (state == S_RESP) && !we_q;
    assign resp_store = (state == S_RESP) && we_q && in_range && !Rst;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LD;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        ready    = (state == S_IDLE) && !Rst;
        done     = (state == S_RESP) && !Rst;
        addr_err = (state == S_RESP) && !Rst && !in_range;
        rdata    = resp_load ? load_data : rdata_q;
    end

    // -------------------------------------------------------------------------
    // Control and request registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 16'h0000;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q  <= addr;
                we_q    <= we;
                wdata_q <= wdata;
            end
            if (resp_load) begin
                rdata_q <= load_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage: not cleared by reset; written on the edge that ends RESP.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (resp_store) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances: dut with WAIT_CYCLES=2,
// dut0 with WAIT_CYCLES=0; they share we/addr/wdata/Rst but have separate
// req lines. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        Clk;
    logic        Rst;
    logic        req, req0, we;
    logic [15:0] addr, wdata;
    logic        ready, done, addr_err;
    logic [15:0] rdata;
    logic        ready0, done0, addr_err0;
    logic [15:0] rdata0;

    int          chk_cnt;
    int          pass_cnt;

    int          lat;
    logic [15:0] rd;
    logic        err;

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Rst(Rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .addr_err(addr_err)
    );

    dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready0), .done(done0), .rdata(rdata0), .addr_err(addr_err0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // One transaction on dut (z=0) or dut0 (z=1). The address and data are
    // scrambled right after the accepting edge. lat is the cycle index of
    // done counted from the accepting edge (20 means it never came).
    task automatic xact(input bit z, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int l,
                        output logic [15:0] r, output logic e);
        @(negedge Clk);
        we = w; addr = a; wdata = d;
        if (z) req0 = 1'b1; else req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req = 1'b0; req0 = 1'b0; addr = ~a; wdata = ~d;
        l = 1;
        while (!(z ? done0 : done) && l < 20) begin
            @(negedge Clk);
            l++;
        end
        r = z ? rdata0 : rdata;
        e = z ? addr_err0 : addr_err;
    endtask

    task automatic test_reset();
        Rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0;
        addr = 16'h0000; wdata = 16'h0000;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        chk_cnt++;
        if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready);
        else pass_cnt++;
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
        else pass_cnt++;
        chk_cnt++;
        if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b expected 0", addr_err);
        else pass_cnt++;
        chk_cnt++;
        if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h expected 0000", rdata);
        else pass_cnt++;
        chk_cnt++;
        if (ready0 !== 1'b1) $display("FAIL reset_ready0: got %b expected 1", ready0);
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        xact(0, 1'b1, 16'h0010, 16'hBEEF, lat, rd, err);
        chk_cnt++;
        if (lat !== 3) $display("FAIL store_latency: got %0d expected 3", lat);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL store_addr_err: got %b expected 0", err);
        else pass_cnt++;
        xact(0, 1'b0, 16'h0010, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (lat !== 3) $display("FAIL load_latency: got %0d expected 3", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 16'hBEEF) $display("FAIL load_rdata: got %h expected beef", rd);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL load_addr_err: got %b expected 0", err);
        else pass_cnt++;
        @(negedge Clk);
        chk_cnt++;
        if (done !== 1'b0 || rdata !== 16'hBEEF)
            $display("FAIL load_hold: got done=%b rdata=%h expected done=0 rdata=beef", done, rdata);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        xact(0, 1'b1, 16'h0000, 16'h5A5A, lat, rd, err);
        xact(0, 1'b1, 16'h0100, 16'hDEAD, lat, rd, err);
        chk_cnt++;
        if (lat !== 3 || err !== 1'b1)
            $display("FAIL oor_store: got lat=%0d err=%b expected lat=3 err=1", lat, err);
        else pass_cnt++;
        xact(0, 1'b0, 16'h0000, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'h5A5A || err !== 1'b0)
            $display("FAIL oor_alias_load: got rdata=%h err=%b expected 5a5a err=0", rd, err);
        else pass_cnt++;
        xact(0, 1'b0, 16'h0100, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'h0000) $display("FAIL oor_load_rdata: got %h expected 0000", rd);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL oor_load_err: got %b expected 1", err);
        else pass_cnt++;
    endtask

    // req held high for 16 cycles with a new address every cycle. Only the
    // first address (0x0010) is in range; the rest are out of range loads.
    task automatic test_back_to_back();
        int acc, dn;
        acc = 0; dn = 0;
        @(negedge Clk);
        we = 1'b0; req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = (i == 0) ? 16'h0010 : (16'h0100 + 16'(i));
            if (done) dn++;
            if (ready) acc++;
            if (i == 3) begin
                chk_cnt++;
                if (done !== 1'b1 || rdata !== 16'hBEEF)
                    $display("FAIL b2b_first: got done=%b rdata=%h expected done=1 rdata=beef", done, rdata);
                else pass_cnt++;
            end
            if (i == 7) begin
                chk_cnt++;
                if (done !== 1'b1 || addr_err !== 1'b1 || rdata !== 16'h0000)
                    $display("FAIL b2b_second: got done=%b err=%b rdata=%h expected 1 1 0000", done, addr_err, rdata);
                else pass_cnt++;
            end
            @(negedge Clk);
        end
        req = 1'b0;
        chk_cnt++;
        if (acc !== 4) $display("FAIL b2b_accepts: got %0d expected 4", acc);
        else pass_cnt++;
        chk_cnt++;
        if (dn !== 4) $display("FAIL b2b_dones: got %0d expected 4", dn);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int dn;
        xact(0, 1'b1, 16'h0020, 16'h1234, lat, rd, err);
        xact(0, 1'b0, 16'h0020, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'h1234) $display("FAIL abort_setup: got %h expected 1234", rd);
        else pass_cnt++;
        // Reset during WAIT
        @(negedge Clk);
        we = 1'b1; addr = 16'h0020; wdata = 16'hFFFF; req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req = 1'b0; Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dn++;
            @(negedge Clk);
        end
        chk_cnt++;
        if (dn !== 0) $display("FAIL abort_wait_done: got %0d pulses expected 0", dn);
        else pass_cnt++;
        chk_cnt++;
        if (rdata !== 16'h0000) $display("FAIL abort_rdata_cleared: got %h expected 0000", rdata);
        else pass_cnt++;
        // Reset during RESP
        we = 1'b1; addr = 16'h0020; wdata = 16'h7777; req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk_cnt++;
        if (done !== 1'b0) $display("FAIL abort_resp_done: got %b expected 0", done);
        else pass_cnt++;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        xact(0, 1'b0, 16'h0020, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'h1234 || lat !== 3)
            $display("FAIL abort_storage: got rdata=%h lat=%0d expected 1234 lat=3", rd, lat);
        else pass_cnt++;
    endtask

    task automatic test_latch();
        int l;
        xact(0, 1'b1, 16'h0041, 16'h1111, lat, rd, err);
        @(negedge Clk);
        we = 1'b1; addr = 16'h0040; wdata = 16'hCAFE; req = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        req = 1'b0; we = 1'b0; addr = 16'h0041; wdata = 16'h0BAD;
        l = 1;
        while (!done && l < 20) begin
            @(negedge Clk);
            l++;
        end
        chk_cnt++;
        if (l !== 3 || addr_err !== 1'b0)
            $display("FAIL latch_store: got lat=%0d err=%b expected lat=3 err=0", l, addr_err);
        else pass_cnt++;
        xact(0, 1'b0, 16'h0040, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'hCAFE) $display("FAIL latch_load_0040: got %h expected cafe", rd);
        else pass_cnt++;
        xact(0, 1'b0, 16'h0041, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (rd !== 16'h1111) $display("FAIL latch_load_0041: got %h expected 1111", rd);
        else pass_cnt++;
    endtask

    task automatic test_wait0();
        int acc, dn;
        xact(1, 1'b1, 16'h0005, 16'h4321, lat, rd, err);
        chk_cnt++;
        if (lat !== 1 || err !== 1'b0)
            $display("FAIL w0_store: got lat=%0d err=%b expected lat=1 err=0", lat, err);
        else pass_cnt++;
        xact(1, 1'b0, 16'h0005, 16'h0000, lat, rd, err);
        chk_cnt++;
        if (lat !== 1) $display("FAIL w0_load_latency: got %0d expected 1", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 16'h4321) $display("FAIL w0_load_rdata: got %h expected 4321", rd);
        else pass_cnt++;
        acc = 0; dn = 0;
        @(negedge Clk);
        we = 1'b0; addr = 16'h0005; req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done0) dn++;
            if (ready0) acc++;
            @(negedge Clk);
        end
        req0 = 1'b0;
        chk_cnt++;
        if (acc !== 4) $display("FAIL w0_b2b_accepts: got %0d expected 4", acc);
        else pass_cnt++;
        chk_cnt++;
        if (dn !== 4) $display("FAIL w0_b2b_dones: got %0d expected 4", dn);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_store_load();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_latch();
        test_wait0();
        repeat (2) @(negedge Clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
